legv8_control_unit: RTL and testbench

LEGV8_CONTROL_UNIT -- requirements
Module: legv8_control_unit

---
 rtl/legv8_pkg.sv | 71 +++++++
 rtl/legv8_control_unit_if.sv | 34 +++
 rtl/legv8_decode.sv | 103 ++++++++++
 rtl/legv8_control_unit.sv | 123 ++++++++++++
 tb/tb_legv8_control_unit.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// ----------------------------------------------------------------------------
// legv8_pkg
// Shared definitions for the LEGv8 multi-cycle control unit:
//   - opcode constants (each at its natural field width)
//   - ALU function-select (FS) codes
//   - FSM state enum
//   - control-word layout (packed struct + bit offsets) and the idle word
// ----------------------------------------------------------------------------
package legv8_pkg;

    // Opcode constants. Widths follow the instruction format that owns them.
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    // ALU function-select codes
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;
    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;

    // X31 is the zero register; used as the "don't care / no write" target
    localparam logic [4:0] REG_ZR = 5'd31;

    // Control word bit offsets, LSB = 0
    localparam int CW_W     = 23;
    localparam int CW_SD    = 0;
    localparam int CW_FS_LO = 1;
    localparam int CW_MW    = 6;
    localparam int CW_RW    = 7;
    localparam int CW_DA_LO = 8;
    localparam int CW_SB_LO = 13;
    localparam int CW_SA_LO = 18;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } state_t;

    // Field order matches the control-word bit layout, MSB first
    typedef struct packed {
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] da;
        logic       reg_write;
        logic       mem_write;
        logic [4:0] fs;
        logic       sd;
    } ctrl_t;

    // Word driven whenever nothing is executing: no writes, DA=X31, SD=0
    localparam ctrl_t CTRL_NOP = '{
        sa:        REG_ZR,
        sb:        REG_ZR,
        da:        REG_ZR,
        reg_write: 1'b0,
        mem_write: 1'b0,
        fs:        FS_ADD,
        sd:        1'b0
    };

endpackage

// File: rtl/legv8_control_unit_if.sv
// ----------------------------------------------------------------------------
// legv8_control_unit_if
// Fetch / datapath bundle between the control unit and its environment.
//   instr_data, instr_valid : fetched instruction and its qualifier
//   status                  : ALU flags {V,C,N,Z}
//   instr_req, pc           : fetch request and address
//   control_word, Const,
//   Bsel                    : datapath controls
//   halted, retired         : stop indicator and retired-instruction count
// modport master : the control unit
// modport slave  : fetch unit / datapath side
// ----------------------------------------------------------------------------
interface legv8_control_unit_if;
    logic [31:0] instr_data;
    logic        instr_valid;
    logic [3:0]  status;
    logic        instr_req;
    logic [63:0] pc;
    logic [22:0] control_word;
    logic [63:0] Const;
    logic        Bsel;
    logic        halted;
    logic [31:0] retired;

    modport master (
        input  instr_data, instr_valid, status,
        output instr_req, pc, control_word, Const, Bsel, halted, retired
    );

    modport slave (
        output instr_data, instr_valid, status,
        input  instr_req, pc, control_word, Const, Bsel, halted, retired
    );
endinterface

// File: rtl/legv8_decode.sv
// ----------------------------------------------------------------------------
// legv8_decode
// Purely combinational instruction decoder.
//   i_ir      : instruction register
//   o_ctrl    : control-word fields for the EXEC cycle
//   o_const   : immediate operand for the datapath
//   o_bsel    : 1 = Const feeds ALU B
//   o_is_b    : unconditional branch
//   o_is_cbz  : compare-and-branch-if-zero
//   o_br_off  : sign-extended, word-scaled branch offset
//   o_illegal : opcode not in the supported set
// ----------------------------------------------------------------------------
module legv8_decode
    import legv8_pkg::*;
(
    input  logic [31:0] i_ir,
    output ctrl_t       o_ctrl,
    output logic [63:0] o_const,
    output logic        o_bsel,
    output logic        o_is_b,
    output logic        o_is_cbz,
    output logic [63:0] o_br_off,
    output logic        o_illegal
);

    logic [4:0]  w_rd;
    logic [4:0]  w_rn;
    logic [4:0]  w_rm;
    logic [11:0] w_imm12;
    logic [8:0]  w_imm9;
    logic [18:0] w_imm19;
    logic [25:0] w_imm26;

    // Rt shares the Rd slot in D- and CB-format instructions
    assign w_rd    = i_ir[4:0];
    assign w_rn    = i_ir[9:5];
    assign w_rm    = i_ir[20:16];
    assign w_imm12 = i_ir[21:10];
    assign w_imm9  = i_ir[20:12];
    assign w_imm19 = i_ir[23:5];
    assign w_imm26 = i_ir[25:0];

    always_comb begin
        o_ctrl    = CTRL_NOP;
        o_const   = '0;
        o_bsel    = 1'b0;
        o_is_b    = 1'b0;
        o_is_cbz  = 1'b0;
        o_br_off  = '0;
        o_illegal = 1'b0;

        // Shortest opcodes first; the encodings do not overlap
        if (i_ir[31:26] == OP_B) begin
            o_is_b   = 1'b1;
            o_br_off = {{36{w_imm26[25]}}, w_imm26, 2'b00};
        end else if (i_ir[31:24] == OP_CBZ) begin
            // Rt + 0 goes through the ALU so the datapath raises Z for it
            o_ctrl.sa = w_rd;
            o_bsel    = 1'b1;
            o_is_cbz  = 1'b1;
            o_br_off  = {{43{w_imm19[18]}}, w_imm19, 2'b00};
        end else if (i_ir[31:22] == OP_ADDI || i_ir[31:22] == OP_SUBI) begin
            o_ctrl.sa        = w_rn;
            o_ctrl.da        = w_rd;
            o_ctrl.reg_write = 1'b1;
            o_ctrl.fs        = (i_ir[31:22] == OP_ADDI) ? FS_ADD : FS_SUB;
            o_bsel           = 1'b1;
            o_const          = {52'd0, w_imm12};
        end else begin
            case (i_ir[31:21])
                OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                    o_ctrl.sa        = w_rn;
                    o_ctrl.sb        = w_rm;
                    o_ctrl.da        = w_rd;
                    o_ctrl.reg_write = 1'b1;
                    case (i_ir[31:21])
                        OP_SUB:  o_ctrl.fs = FS_SUB;
                        OP_AND:  o_ctrl.fs = FS_AND;
                        OP_ORR:  o_ctrl.fs = FS_ORR;
                        default: o_ctrl.fs = FS_ADD;
                    endcase
                end
                OP_LDUR: begin
                    o_ctrl.sa        = w_rn;
                    o_ctrl.da        = w_rd;
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.sd        = 1'b1;
                    o_bsel           = 1'b1;
                    o_const          = {{55{w_imm9[8]}}, w_imm9};
                end
                OP_STUR: begin
                    o_ctrl.sa        = w_rn;
                    o_ctrl.sb        = w_rd;
                    o_ctrl.mem_write = 1'b1;
                    o_bsel           = 1'b1;
                    o_const          = {{55{w_imm9[8]}}, w_imm9};
                end
                default: o_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/legv8_control_unit.sv
// ----------------------------------------------------------------------------
// legv8_control_unit
// Multi-cycle LEGv8 control unit: FETCH -> DECODE -> EXEC -> FETCH, with
// HALT on an illegal opcode (left only through reset).
//   clock : system clock, rising edge
//   reset : synchronous, active high
//   bus   : master side of legv8_control_unit_if (fetch handshake,
//           status flags in; pc, control word, Const, Bsel, halted,
//           retired out)
// ----------------------------------------------------------------------------
module legv8_control_unit
    import legv8_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    legv8_control_unit_if.master        bus
);

    // Write enables that reset must kill combinationally
    localparam logic [CW_W-1:0] WR_MASK = (CW_W'(1) << CW_RW) | (CW_W'(1) << CW_MW);

    state_t      r_state;
    logic [31:0] r_ir;
    logic [63:0] r_pc;
    ctrl_t       r_cw;
    logic [63:0] r_const;
    logic        r_bsel;
    logic        r_is_b;
    logic        r_is_cbz;
    logic [63:0] r_br_off;
    logic        r_halted;
    logic        r_instr_req;
    logic [31:0] r_retired;

    ctrl_t       w_dec_ctrl;
    logic [63:0] w_dec_const;
    logic        w_dec_bsel;
    logic        w_dec_is_b;
    logic        w_dec_is_cbz;
    logic [63:0] w_dec_br_off;
    logic        w_dec_illegal;
    logic        w_take_branch;
    logic        w_unused_flags;

    legv8_decode u_decode (
        .i_ir      (r_ir),
        .o_ctrl    (w_dec_ctrl),
        .o_const   (w_dec_const),
        .o_bsel    (w_dec_bsel),
        .o_is_b    (w_dec_is_b),
        .o_is_cbz  (w_dec_is_cbz),
        .o_br_off  (w_dec_br_off),
        .o_illegal (w_dec_illegal)
    );

    // Only Z steers control flow; N, C, V are part of the bus but unused here
    assign w_unused_flags = ^bus.status[3:1];
    assign w_take_branch  = r_is_b || (r_is_cbz && bus.status[0]);

    // r_cw holds the decoded word only for the single EXEC cycle and the
    // idle word otherwise, so the output needs no state decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_ir        <= '0;
            r_pc        <= '0;
            r_cw        <= CTRL_NOP;
            r_const     <= '0;
            r_bsel      <= 1'b0;
            r_is_b      <= 1'b0;
            r_is_cbz    <= 1'b0;
            r_br_off    <= '0;
            r_halted    <= 1'b0;
            r_instr_req <= 1'b1;
            r_retired   <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (bus.instr_valid) begin
                        r_ir        <= bus.instr_data;
                        r_instr_req <= 1'b0;
                        r_state     <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_const  <= w_dec_const;
                    r_bsel   <= w_dec_bsel;
                    r_is_b   <= w_dec_is_b;
                    r_is_cbz <= w_dec_is_cbz;
                    r_br_off <= w_dec_br_off;
                    if (w_dec_illegal) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else begin
                        r_cw    <= w_dec_ctrl;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_cw        <= CTRL_NOP;
                    r_pc        <= w_take_branch ? (r_pc + r_br_off) : (r_pc + 64'd4);
                    r_retired   <= r_retired + 32'd1;
                    r_instr_req <= 1'b1;
                    r_state     <= ST_FETCH;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    // Reset must stop register/memory writes in the same cycle it appears,
    // even mid-EXEC, before the registered word is cleared at the edge.
    assign bus.control_word = reset ? (r_cw & ~WR_MASK) : r_cw;
    assign bus.instr_req    = r_instr_req;
    assign bus.pc           = r_pc;
    assign bus.Const        = r_const;
    assign bus.Bsel         = r_bsel;
    assign bus.halted       = r_halted;
    assign bus.retired      = r_retired;

endmodule

// File: tb/tb_legv8_control_unit.sv
module tb_legv8_control_unit;

    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    legv8_control_unit_if u_if ();

    legv8_control_unit u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (u_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic do_reset();
        reset = 1'b1;
        u_if.instr_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Runs one instruction through FETCH/DECODE/EXEC. Samples the control word
    // in DECODE and in EXEC, then applies st so it is seen at the EXEC edge.
    task automatic issue(input logic [31:0] instr, input logic [3:0] st,
                         output logic [22:0] cw_d, output logic [22:0] cw_e,
                         output logic [63:0] c_e, output logic b_e);
        int n;
        n = 0;
        while (u_if.instr_req !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        n_checks++;
        if (u_if.instr_req !== 1'b1)
            $display("FAIL fetch_wait: instr_req=%b after %0d cycles, required 1", u_if.instr_req, n);
        else
            n_pass++;
        u_if.instr_data  = instr;
        u_if.instr_valid = 1'b1;
        @(posedge clock); #1;
        u_if.instr_valid = 1'b0;
        cw_d = u_if.control_word;
        @(posedge clock); #1;
        cw_e = u_if.control_word;
        c_e  = u_if.Const;
        b_e  = u_if.Bsel;
        u_if.status = st;
        @(posedge clock); #1;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b1;
        u_if.instr_valid = 1'b0;
        u_if.instr_data  = 32'h0;
        u_if.status      = 4'h0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({u_if.pc, u_if.retired, u_if.halted} !== {64'd0, 32'd0, 1'b0})
            $display("FAIL reset_state: pc=%h retired=%0d halted=%b, required 0/0/0",
                     u_if.pc, u_if.retired, u_if.halted);
        else n_pass++;
        n_checks++;
        if (u_if.control_word[7:6] !== 2'b00)
            $display("FAIL reset_writes: RW/MW=%b, required 00", u_if.control_word[7:6]);
        else n_pass++;
        reset = 1'b0;
        n_checks++;
        if (u_if.instr_req !== 1'b1)
            $display("FAIL reset_req: instr_req=%b, required 1", u_if.instr_req);
        else n_pass++;
    endtask

    task automatic test_addi();
        logic [22:0] cd, ce; logic [63:0] c; logic b;
        issue(32'h910017E1, 4'h0, cd, ce, c, b);
        n_checks++;
        if ({ce[22:18], ce[12:8], ce[7], ce[5:1], b, c} !== {5'd31, 5'd1, 1'b1, 5'b01000, 1'b1, 64'd5})
            $display("FAIL addi_exec: cw=%h bsel=%b const=%h, required SA=31 DA=1 RW=1 FS=01000 Bsel=1 Const=5",
                     ce, b, c);
        else n_pass++;
        n_checks++;
        if (u_if.pc !== 64'd4 || u_if.retired !== 32'd1)
            $display("FAIL addi_pc: pc=%h retired=%0d, required 4/1", u_if.pc, u_if.retired);
        else n_pass++;
    endtask

    task automatic test_branch();
        logic [22:0] cd, ce; logic [63:0] c; logic b;
        issue({6'b000101, 26'd3}, 4'h0, cd, ce, c, b);
        n_checks++;
        if (u_if.pc !== 64'h10 || ce[7:6] !== 2'b00)
            $display("FAIL b_fwd: pc=%h RW/MW=%b, required 10/00", u_if.pc, ce[7:6]);
        else n_pass++;
        issue({8'b10110100, 19'd3, 5'd5}, 4'b0001, cd, ce, c, b);
        n_checks++;
        if ({ce[22:18], ce[7:6], ce[5:1], b, c} !== {5'd5, 2'b00, 5'b01000, 1'b1, 64'd0})
            $display("FAIL cbz_exec: cw=%h bsel=%b const=%h, required SA=5 no writes FS=ADD Bsel=1 Const=0",
                     ce, b, c);
        else n_pass++;
        n_checks++;
        if (u_if.pc !== 64'h1C)
            $display("FAIL cbz_taken: pc=%h, required 1c", u_if.pc);
        else n_pass++;
        issue(32'h910017E1, 4'h0, cd, ce, c, b);
        issue({6'b000101, 26'h3FFFFFF}, 4'h0, cd, ce, c, b);
        n_checks++;
        if (u_if.pc !== 64'h1C || u_if.retired !== 32'd5)
            $display("FAIL b_back: pc=%h retired=%0d, required 1c/5", u_if.pc, u_if.retired);
        else n_pass++;
        do_reset();
        issue({6'b000101, 26'd4}, 4'h0, cd, ce, c, b);
        issue({8'b10110100, 19'd3, 5'd5}, 4'b0000, cd, ce, c, b);
        n_checks++;
        if (u_if.pc !== 64'h14 || u_if.retired !== 32'd2)
            $display("FAIL cbz_not_taken: pc=%h retired=%0d, required 14/2", u_if.pc, u_if.retired);
        else n_pass++;
    endtask

    task automatic test_stall();
        u_if.instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            n_checks++;
            if ({u_if.instr_req, u_if.pc, u_if.control_word[7:6]} !== {1'b1, 64'h14, 2'b00})
                $display("FAIL stall_%0d: req=%b pc=%h RW/MW=%b, required 1/14/00",
                         i, u_if.instr_req, u_if.pc, u_if.control_word[7:6]);
            else n_pass++;
        end
    endtask

    task automatic test_stur();
        logic [22:0] cd, ce; logic [63:0] c; logic b;
        issue({11'b11111000000, 9'h1F8, 2'b00, 5'd3, 5'd2}, 4'h0, cd, ce, c, b);
        n_checks++;
        if ({ce[22:18], ce[17:13], ce[7:6], ce[5:1], b, c} !==
            {5'd3, 5'd2, 2'b01, 5'b01000, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8})
            $display("FAIL stur_exec: cw=%h bsel=%b const=%h, required SA=3 SB=2 RW=0 MW=1 Const=fff..ff8",
                     ce, b, c);
        else n_pass++;
        n_checks++;
        if (u_if.pc !== 64'h18 || u_if.retired !== 32'd3)
            $display("FAIL stur_pc: pc=%h retired=%0d, required 18/3", u_if.pc, u_if.retired);
        else n_pass++;
    endtask

    // Random legal instructions against a field-level model of the ISA rules
    task automatic test_random();
        logic [31:0] instr, ret_exp;
        logic [3:0]  st;
        logic [4:0]  ra, rb, rc, fs;
        logic [10:0] opc;
        logic [11:0] i12;
        logic [8:0]  i9;
        logic [18:0] i19;
        logic [25:0] i26;
        logic [22:0] exp_cw, mask, cd, ce;
        logic [63:0] exp_c, c, pc_exp, off;
        logic        exp_b, b, care_c, taken;
        int          kind;
        do_reset();
        pc_exp  = 64'd0;
        ret_exp = 32'd0;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            ra = 5'($urandom); rb = 5'($urandom); rc = 5'($urandom);
            i12 = 12'($urandom); i9 = 9'($urandom);
            i19 = 19'($urandom); i26 = 26'($urandom);
            st = 4'($urandom);
            care_c = 1'b1; exp_b = 1'b1; exp_c = 64'd0; taken = 1'b0; off = 64'd0;
            mask = {5'h1F, 5'h00, 13'h1FFF};
            case (kind)
                0, 1, 2, 3: begin
                    case (kind)
                        0: begin opc = 11'b10001011000; fs = 5'b01000; end
                        1: begin opc = 11'b11001011000; fs = 5'b01001; end
                        2: begin opc = 11'b10001010000; fs = 5'b00000; end
                        default: begin opc = 11'b10101010000; fs = 5'b00100; end
                    endcase
                    instr  = {opc, rb, 6'd0, ra, rc};
                    exp_cw = {ra, rb, rc, 1'b1, 1'b0, fs, 1'b0};
                    mask   = '1;
                    exp_b  = 1'b0;
                end
                4, 5: begin
                    instr  = {(kind == 4) ? 10'b1001000100 : 10'b1101000100, i12, ra, rc};
                    exp_cw = {ra, 5'd0, rc, 1'b1, 1'b0, (kind == 4) ? 5'b01000 : 5'b01001, 1'b0};
                    exp_c  = 64'(i12);
                end
                6: begin
                    instr  = {11'b11111000010, i9, 2'b00, ra, rc};
                    exp_cw = {ra, 5'd0, rc, 1'b1, 1'b0, 5'b01000, 1'b1};
                    exp_c  = 64'(longint'($signed(i9)));
                end
                7: begin
                    instr  = {11'b11111000000, i9, 2'b00, ra, rc};
                    exp_cw = {ra, rc, 5'd0, 1'b0, 1'b1, 5'b01000, 1'b0};
                    mask   = {10'h3FF, 5'h00, 1'b1, 1'b1, 5'h1F, 1'b0};
                    exp_c  = 64'(longint'($signed(i9)));
                end
                8: begin
                    instr  = {8'b10110100, i19, rc};
                    exp_cw = {rc, 5'd0, 5'd0, 1'b0, 1'b0, 5'b01000, 1'b0};
                    mask   = {5'h1F, 5'h00, 5'h00, 1'b1, 1'b1, 5'h1F, 1'b0};
                    taken  = st[0];
                    off    = 64'(longint'($signed(i19)) * 4);
                end
                default: begin
                    instr  = {6'b000101, i26};
                    exp_cw = '0;
                    mask   = {15'h0, 1'b1, 1'b1, 6'h0};
                    care_c = 1'b0;
                    taken  = 1'b1;
                    off    = 64'(longint'($signed(i26)) * 4);
                end
            endcase
            pc_exp  = taken ? pc_exp + off : pc_exp + 64'd4;
            ret_exp = ret_exp + 32'd1;
            issue(instr, st, cd, ce, c, b);
            n_checks++;
            if ({cd[12:6], cd[0]} !== {5'd31, 2'b00, 1'b0})
                $display("FAIL rnd%0d_decode_idle: cw=%h, required DA=31 RW=0 MW=0 SD=0", i, cd);
            else n_pass++;
            n_checks++;
            if ((ce & mask) !== (exp_cw & mask))
                $display("FAIL rnd%0d_cw: instr=%h cw=%h, required %h (mask %h)", i, instr, ce, exp_cw, mask);
            else n_pass++;
            if (care_c) begin
                n_checks++;
                if ({b, c} !== {exp_b, exp_c})
                    $display("FAIL rnd%0d_const: bsel=%b const=%h, required %b/%h", i, b, c, exp_b, exp_c);
                else n_pass++;
            end
            n_checks++;
            if (u_if.pc !== pc_exp || u_if.retired !== ret_exp || u_if.halted !== 1'b0)
                $display("FAIL rnd%0d_pc: pc=%h retired=%0d halted=%b, required %h/%0d/0",
                         i, u_if.pc, u_if.retired, u_if.halted, pc_exp, ret_exp);
            else n_pass++;
        end
    endtask

    task automatic test_halt();
        logic [22:0] cd, ce; logic [63:0] c; logic b;
        do_reset();
        issue(32'h910017E1, 4'h0, cd, ce, c, b);
        issue(32'h00000000, 4'h1, cd, ce, c, b);
        n_checks++;
        if ({u_if.halted, u_if.instr_req, ce[7:6]} !== 4'b1000)
            $display("FAIL halt_enter: halted=%b req=%b RW/MW=%b, required 1/0/00",
                     u_if.halted, u_if.instr_req, ce[7:6]);
        else n_pass++;
        u_if.instr_valid = 1'b1;
        u_if.instr_data  = 32'h910017E1;
        repeat (4) @(posedge clock);
        #1;
        u_if.instr_valid = 1'b0;
        n_checks++;
        if ({u_if.halted, u_if.instr_req, u_if.pc, u_if.retired} !== {1'b1, 1'b0, 64'd4, 32'd1})
            $display("FAIL halt_frozen: halted=%b req=%b pc=%h retired=%0d, required 1/0/4/1",
                     u_if.halted, u_if.instr_req, u_if.pc, u_if.retired);
        else n_pass++;
    endtask

    task automatic test_reset_in_exec();
        logic [22:0] cd, ce; logic [63:0] c; logic b;
        do_reset();
        issue(32'h910017E1, 4'h0, cd, ce, c, b);
        u_if.instr_data  = {11'b11111000000, 9'h1F8, 2'b00, 5'd3, 5'd2};
        u_if.instr_valid = 1'b1;
        @(posedge clock); #1;
        u_if.instr_valid = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (u_if.control_word[6] !== 1'b1)
            $display("FAIL rst_exec_pre: MW=%b, required 1", u_if.control_word[6]);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (u_if.control_word[7:6] !== 2'b00)
            $display("FAIL rst_exec_mask: RW/MW=%b, required 00", u_if.control_word[7:6]);
        else n_pass++;
        @(posedge clock); #1;
        n_checks++;
        if (u_if.pc !== 64'd0 || u_if.retired !== 32'd0 || u_if.halted !== 1'b0)
            $display("FAIL rst_exec_post: pc=%h retired=%0d halted=%b, required 0/0/0",
                     u_if.pc, u_if.retired, u_if.halted);
        else n_pass++;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_stall();
        test_stur();
        test_random();
        test_halt();
        test_reset_in_exec();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
